// File: rtl/exemem_multilane_reg.sv
// rtl/exemem_multilane_reg.sv - multi-lane EX/MEM pipeline register with kill, compaction and bubble counting
//
// Carries LANES per-lane payloads plus one shared payload from EX to MEM.
// Update priority per edge: flush > stall_cur (hold) > stall_prev (bubble) > load.
//
// Ports:
//   clk, resetn                 clock (rising edge), asynchronous active-low reset
//   stall_cur                   hold every register, bubble counter included
//   stall_prev                  upstream stalled: insert a bubble
//   flush                       squash contents (wins over stall_cur)
//   in_valid / in_kill          per-lane valid; kill[i] squashes lane i and all younger lanes
//   in_lane_data / in_shared    lane i at [i*LANE_W +: LANE_W]; shared payload
//   out_valid / out_lane_data   registered per-lane valid and payloads (invalid lanes are zero)
//   out_shared                  registered shared payload (zero when no lane survived)
//   out_count                   registered popcount of out_valid
//   bubble_cnt                  saturating count of edges that left out_valid all-zero
module exemem_multilane_reg #(
    parameter int LANES    = 2,
    parameter int LANE_W   = 112,
    parameter int SHARED_W = 142,
    parameter int COMPACT  = 1,
    parameter int CNT_W    = 16,
    localparam int CW      = $clog2(LANES + 1)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     stall_cur,
    input  logic                     stall_prev,
    input  logic                     flush,
    input  logic [LANES-1:0]         in_valid,
    input  logic [LANES-1:0]         in_kill,
    input  logic [LANES*LANE_W-1:0]  in_lane_data,
    input  logic [SHARED_W-1:0]      in_shared,
    output logic [LANES-1:0]         out_valid,
    output logic [LANES*LANE_W-1:0]  out_lane_data,
    output logic [SHARED_W-1:0]      out_shared,
    output logic [CW-1:0]            out_count,
    output logic [CNT_W-1:0]         bubble_cnt
);

    logic [LANES-1:0]        valid_q, valid_d;
    logic [LANES*LANE_W-1:0] data_q, data_d;
    logic [SHARED_W-1:0]     shared_q, shared_d;
    logic [CW-1:0]           count_q, count_d;
    logic [CNT_W-1:0]        bcnt_q, bcnt_d;

    logic [LANES-1:0]        surv;
    logic                    alive;
    logic [LANES-1:0]        ld_valid;
    logic [LANES*LANE_W-1:0] ld_data;
    logic [SHARED_W-1:0]     ld_shared;
    logic [CW-1:0]           ld_count;
    logic [CNT_W-1:0]        bcnt_inc;

    // Surviving lanes and the load image. A kill on lane i closes the window
    // for lane i and everything younger, independent of that lane's valid.
    always_comb begin
        int pos;
        surv      = '0;
        alive     = 1'b1;
        ld_valid  = '0;
        ld_data   = '0;
        pos       = 0;
        for (int i = 0; i < LANES; i++) begin
            alive   = alive & ~in_kill[i];
            surv[i] = alive & in_valid[i];
        end
        for (int i = 0; i < LANES; i++) begin
            if (surv[i]) begin
                if (COMPACT != 0) begin
                    ld_valid[pos]                     = 1'b1;
                    ld_data[pos*LANE_W +: LANE_W]     = in_lane_data[i*LANE_W +: LANE_W];
                end else begin
                    ld_valid[i]                       = 1'b1;
                    ld_data[i*LANE_W +: LANE_W]       = in_lane_data[i*LANE_W +: LANE_W];
                end
                pos = pos + 1;
            end
        end
        ld_count  = CW'(pos);
        ld_shared = (|surv) ? in_shared : '0;
    end

    assign bcnt_inc = (bcnt_q == {CNT_W{1'b1}}) ? bcnt_q : bcnt_q + 1'b1;

    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        shared_d = shared_q;
        count_d  = count_q;
        bcnt_d   = bcnt_q;
        if (flush || (!stall_cur && stall_prev)) begin
            valid_d  = '0;
            data_d   = '0;
            shared_d = '0;
            count_d  = '0;
            bcnt_d   = bcnt_inc;
        end else if (!stall_cur) begin
            valid_d  = ld_valid;
            data_d   = ld_data;
            shared_d = ld_shared;
            count_d  = ld_count;
            if (ld_valid == '0) begin
                bcnt_d = bcnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q  <= '0;
            data_q   <= '0;
            shared_q <= '0;
            count_q  <= '0;
            bcnt_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            shared_q <= shared_d;
            count_q  <= count_d;
            bcnt_q   <= bcnt_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_lane_data = data_q;
    assign out_shared    = shared_q;
    assign out_count     = count_q;
    assign bubble_cnt    = bcnt_q;

endmodule
